// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle sequencer and the MIPS datapath: the opcode and
// memory handshake flow in, per-cycle datapath strobes and status flow out.
interface multicycle_control_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             Op;
    logic                   mem_ready;
    logic                   PCWrite;
    logic                   PCWriteCond;
    logic                   BranchNe;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic                   MemtoReg;
    logic                   RegDst;
    logic                   RegWrite;
    logic                   ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [1:0]             ALUOp;
    logic [1:0]             PCSource;
    logic [3:0]             state;
    logic                   illegal;
    logic [COUNT_WIDTH-1:0] instr_count;

    // Sequencer side: consumes opcode/handshake, drives strobes.
    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, state, illegal, instr_count
    );

    // Datapath side: supplies opcode/handshake, consumes strobes.
    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, state, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and counts retired instructions.
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_reg;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   retire;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (retire) begin
            count_reg <= count_reg + COUNT_ONE;
        end
    end

    // Next-state and strobe decode; strobes are forced low while reset is held
    // so nothing reaches the datapath between reset assertion and the edge.
    always_comb begin
        state_next       = state_reg;
        retire           = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.BranchNe     = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'd0;
        bus.ALUOp        = 2'd0;
        bus.PCSource     = 2'd0;
        bus.illegal      = 1'b0;

        case (state_reg)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'd1;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_next  = DECODE;
                end
            end
            DECODE: begin
                bus.ALUSrcB = 2'd3;
                case (bus.Op)
                    OP_RTYPE:       state_next = EXEC;
                    OP_LW, OP_SW:   state_next = MEMADR;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_J:           state_next = JUMP;
                    OP_ADDI:        state_next = ADDI_EX;
                    default: begin
                        bus.illegal = 1'b1;
                        retire      = 1'b1;
                        state_next  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                state_next  = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                retire       = 1'b1;
                state_next   = FETCH;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'd2;
                state_next  = RWB;
            end
            RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                retire       = 1'b1;
                state_next   = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'd1;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'd1;
                bus.BranchNe    = bus.Op[0];
                retire          = 1'b1;
                state_next      = FETCH;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'd2;
                retire       = 1'b1;
                state_next   = FETCH;
            end
            ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                state_next  = ADDI_WB;
            end
            ADDI_WB: begin
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_next   = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (reset) begin
            retire          = 1'b0;
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.BranchNe    = 1'b0;
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.MemtoReg    = 1'b0;
            bus.RegDst      = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.ALUSrcA     = 1'b0;
            bus.ALUSrcB     = 2'd0;
            bus.ALUOp       = 2'd0;
            bus.PCSource    = 2'd0;
            bus.illegal     = 1'b0;
        end
    end

    assign bus.state       = state_reg;
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multi-cycle sequencer: walks R-type, lw with stalls,
// bne, an illegal opcode, reset during a stalled store and counter wrap on j.
module tb_multicycle_control;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    multicycle_control_if #(.COUNT_WIDTH(32)) bus ();

    multicycle_control #(.COUNT_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, observed, expected);
    endtask

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.Op        = 6'h00;
        #1;
        // Reset state: FETCH, counter clear, all strobes low even in FETCH.
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_count", bus.instr_count, 32'd0);
        check("rst_memread", 32'(bus.MemRead), 32'd0);
        check("rst_alusrcb", 32'(bus.ALUSrcB), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        // FETCH stalled on memory.
        check("fetch_state", 32'(bus.state), 32'd0);
        check("fetch_memread", 32'(bus.MemRead), 32'd1);
        check("fetch_alusrcb", 32'(bus.ALUSrcB), 32'd1);
        check("fetch_irwrite_wait", 32'(bus.IRWrite), 32'd0);
        check("fetch_pcwrite_wait", 32'(bus.PCWrite), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_irwrite_rdy", 32'(bus.IRWrite), 32'd1);
        check("fetch_pcwrite_rdy", 32'(bus.PCWrite), 32'd1);

        // R-type: 0,1,6,7,0
        next_cycle();
        check("r_decode", 32'(bus.state), 32'd1);
        check("r_dec_alusrcb", 32'(bus.ALUSrcB), 32'd3);
        check("r_dec_memread", 32'(bus.MemRead), 32'd0);
        next_cycle();
        check("r_exec", 32'(bus.state), 32'd6);
        check("r_exec_aluop", 32'(bus.ALUOp), 32'd2);
        check("r_exec_srca", 32'(bus.ALUSrcA), 32'd1);
        check("r_exec_regwrite", 32'(bus.RegWrite), 32'd0);
        next_cycle();
        check("r_rwb", 32'(bus.state), 32'd7);
        check("r_rwb_regwrite", 32'(bus.RegWrite), 32'd1);
        check("r_rwb_regdst", 32'(bus.RegDst), 32'd1);
        next_cycle();
        check("r_done_state", 32'(bus.state), 32'd0);
        check("r_done_count", bus.instr_count, 32'd1);

        // lw with three stall cycles in MEMRD.
        bus.Op = 6'h23;
        next_cycle();
        check("lw_decode", 32'(bus.state), 32'd1);
        next_cycle();
        check("lw_memadr", 32'(bus.state), 32'd2);
        check("lw_memadr_srcb", 32'(bus.ALUSrcB), 32'd2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check($sformatf("lw_memrd_state%0d", i), 32'(bus.state), 32'd3);
            check($sformatf("lw_memrd_read%0d", i), 32'(bus.MemRead), 32'd1);
            check($sformatf("lw_memrd_iord%0d", i), 32'(bus.IorD), 32'd1);
            if (i == 3) bus.mem_ready = 1'b1;
        end
        next_cycle();
        check("lw_memwb", 32'(bus.state), 32'd4);
        check("lw_memwb_memtoreg", 32'(bus.MemtoReg), 32'd1);
        check("lw_memwb_regwrite", 32'(bus.RegWrite), 32'd1);
        check("lw_memwb_regdst", 32'(bus.RegDst), 32'd0);
        next_cycle();
        check("lw_done_state", 32'(bus.state), 32'd0);
        check("lw_done_count", bus.instr_count, 32'd2);

        // bne
        bus.Op = 6'h05;
        next_cycle();
        check("bne_decode", 32'(bus.state), 32'd1);
        next_cycle();
        check("bne_branch", 32'(bus.state), 32'd8);
        check("bne_pcwritecond", 32'(bus.PCWriteCond), 32'd1);
        check("bne_branchne", 32'(bus.BranchNe), 32'd1);
        check("bne_aluop", 32'(bus.ALUOp), 32'd1);
        check("bne_pcsource", 32'(bus.PCSource), 32'd1);
        next_cycle();
        check("bne_done_state", 32'(bus.state), 32'd0);
        check("bne_done_count", bus.instr_count, 32'd3);

        // Illegal opcode: retired from DECODE.
        bus.Op = 6'h3F;
        next_cycle();
        check("ill_decode", 32'(bus.state), 32'd1);
        check("ill_pulse", 32'(bus.illegal), 32'd1);
        check("ill_regwrite", 32'(bus.RegWrite), 32'd0);
        check("ill_memwrite", 32'(bus.MemWrite), 32'd0);
        next_cycle();
        check("ill_back_state", 32'(bus.state), 32'd0);
        check("ill_pulse_end", 32'(bus.illegal), 32'd0);
        check("ill_count", bus.instr_count, 32'd4);

        // sw stalled, then reset mid-write.
        bus.Op = 6'h2B;
        next_cycle();
        check("sw_decode", 32'(bus.state), 32'd1);
        next_cycle();
        check("sw_memadr", 32'(bus.state), 32'd2);
        bus.mem_ready = 1'b0;
        next_cycle();
        check("sw_memwr", 32'(bus.state), 32'd5);
        check("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        check("sw_iord", 32'(bus.IorD), 32'd1);
        reset = 1'b1;
        #1;
        check("sw_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("sw_rst_state", 32'(bus.state), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        check("sw_rel_state", 32'(bus.state), 32'd0);
        check("sw_rel_count", bus.instr_count, 32'd0);
        check("sw_rel_memwrite", 32'(bus.MemWrite), 32'd0);

        // Counter wrap on j: preload all-ones while FETCH stalls.
        force dut.count_reg = 32'hFFFF_FFFF;
        next_cycle();
        release dut.count_reg;
        #1;
        check("wrap_preload", bus.instr_count, 32'hFFFF_FFFF);
        bus.Op = 6'h02;
        bus.mem_ready = 1'b1;
        next_cycle();
        check("j_decode", 32'(bus.state), 32'd1);
        next_cycle();
        check("j_jump", 32'(bus.state), 32'd9);
        check("j_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("j_pcsource", 32'(bus.PCSource), 32'd2);
        check("j_count_pre", bus.instr_count, 32'hFFFF_FFFF);
        next_cycle();
        check("j_done_state", 32'(bus.state), 32'd0);
        check("j_wrap_count", bus.instr_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
